hybrid_sequencer: RTL and testbench
===================================

HYBRID_SEQUENCER -- requirements
Module: hybrid_sequencer

Interface
REQ-001 SHALL have parameter DEAD_TIME, default 10: cycles with both gates low at every leg commutation.
REQ-002 SHALL have parameter MIN_DWELL, default 50: minimum cycles between committed leg transitions.
REQ-003 SHALL have parameter RAMP_DIV, default 100: cycles between theta ramp steps.
REQ-004 SHALL have parameter THETA_STEP, default 1000: theta increment per ramp step, 32-bit unsigned.
REQ-005 SHALL have parameter I_LIMIT, default 4000: overcurrent threshold on |i_iC|, 14-bit positive.
REQ-006 SHALL have port i_clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 SHALL have port i_RESET, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port i_enable, input, 1 bit: converter run request.
REQ-009 SHALL have port i_sigma, input, 1 bit: requested leg state from the hybrid control law.
REQ-010 SHALL have port i_iC, input, 14 bits signed: tank current sample.
REQ-011 SHALL have port i_theta_start, input, 32 bits signed: soft-start switching-surface angle.
REQ-012 SHALL have port i_theta_target, input, 32 bits signed: operating angle.
REQ-013 SHALL have port i_fault_clr, input, 1 bit: fault acknowledge.
REQ-014 SHALL have port o_theta, output, 32 bits signed: angle driven to the hybrid control law.
REQ-015 SHALL have ports o_gate_H and o_gate_L, outputs, 1 bit each: high-side and low-side gate commands.
REQ-016 SHALL have port o_state, output, 2 bits: IDLE=0, RAMP=1, RUN=2, FAULT=3.
REQ-017 SHALL have port o_fault, output, 1 bit: high exactly while in FAULT.

Function
REQ-018 All outputs SHALL be registered; o_gate_H and o_gate_L SHALL never be high in the same cycle.
REQ-019 IDLE: gates low, o_theta = i_theta_start; i_enable=1 SHALL move to RAMP on the next edge.
REQ-020 On IDLE->RAMP the leg SHALL start a dead-time period and then commit the i_sigma value sampled at the transition edge.
REQ-021 RAMP: o_theta SHALL load i_theta_start on entry; every RAMP_DIV cycles it SHALL step by THETA_STEP toward i_theta_target in either direction and saturate at the target, with no overshoot.
REQ-022 RAMP SHALL move to RUN on the edge after o_theta equals i_theta_target.
REQ-023 RUN: o_theta SHALL register i_theta_target each cycle, giving 1-cycle latency.
REQ-024 Commutation: when the committed leg state s differs from i_sigma and the dwell counter is >= MIN_DWELL, the block SHALL latch i_sigma, drive both gates low from the next edge for DEAD_TIME cycles, then commit the latched value.
REQ-025 Gate edge latency from an accepted i_sigma change SHALL be DEAD_TIME+1 cycles.
REQ-026 An i_sigma change while dwell < MIN_DWELL SHALL be deferred, with no memory: the current i_sigma is re-evaluated each cycle.
REQ-027 An i_sigma reversal during dead time SHALL be ignored until the latched value is committed.
REQ-028 The dwell counter SHALL reset to 0 on commit and saturate at MIN_DWELL.
REQ-029 Outside dead time, o_gate_H = s and o_gate_L = ~s in RAMP and RUN; both gates SHALL be low in IDLE and FAULT.
REQ-030 Overcurrent: |i_iC| SHALL be computed at 15 bits so that -8192 yields 8192; a value > I_LIMIT in RAMP or RUN SHALL force FAULT on the next edge with gates low in that same cycle.
REQ-031 i_enable=0 in RAMP or RUN SHALL return to IDLE on the next edge with gates low immediately, abandoning any dead time.
REQ-032 Overcurrent SHALL take priority over i_enable=0 in the same cycle.
REQ-033 FAULT SHALL exit to IDLE only when i_fault_clr=1 and i_enable=0 in the same cycle; otherwise the block SHALL remain in FAULT.

Reset
REQ-034 i_RESET=0 SHALL immediately force IDLE, gates low, o_fault=0, o_theta=0 (i_theta_start from the first clock after release), dwell=MIN_DWELL, and ramp and dead-time counters to 0, including mid-dead-time.

Verification
REQ-035 Start: theta_start=0, target=5000, enable=1 -> RAMP; o_theta steps 1000 every 100 cycles; RUN on the edge after o_theta=5000.
REQ-036 Commutation: RUN, s=1, dwell satisfied, i_sigma 1->0 -> both gates low for 10 cycles; o_gate_L rises 11 cycles after the i_sigma change.
REQ-037 Chatter: i_sigma toggles 20 cycles after a commit -> no gate change until dwell reaches 50; check no H/L overlap in any cycle.
REQ-038 Overcurrent: i_iC=-8192 in RUN -> FAULT and gates low next edge; o_fault=1; fault_clr=1 with enable=1 -> stays FAULT; fault_clr=1 with enable=0 -> IDLE.
REQ-039 Reset: assert i_RESET mid-dead-time -> IDLE, gates low asynchronously with no clock edge.
REQ-040 Downward ramp: theta_start=5500, target=3000 -> steps 4500, 3500, then saturates at 3000 with no undershoot.

Source files
------------

// File: rtl/hybrid_sequencer.sv
// Soft-start, commutation and protection sequencer for a half-bridge leg under
// hybrid control: ramps the switching-surface angle, inserts dead time and enforces dwell.
module hybrid_sequencer #(
    parameter int          DEAD_TIME  = 10,
    parameter int          MIN_DWELL  = 50,
    parameter int          RAMP_DIV   = 100,
    parameter logic [31:0] THETA_STEP = 32'd1000,
    parameter logic [13:0] I_LIMIT    = 14'd4000
) (
    input  logic               i_clock,
    input  logic               i_RESET,
    input  logic               i_enable,
    input  logic               i_sigma,
    input  logic signed [13:0] i_iC,
    input  logic signed [31:0] i_theta_start,
    input  logic signed [31:0] i_theta_target,
    input  logic               i_fault_clr,
    output logic signed [31:0] o_theta,
    output logic               o_gate_H,
    output logic               o_gate_L,
    output logic [1:0]         o_state,
    output logic               o_fault
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RAMP  = 2'd1,
        S_RUN   = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam int DTW = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
    localparam int DWW = (MIN_DWELL > 0) ? $clog2(MIN_DWELL + 1) : 1;
    localparam int RDW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DTW-1:0] DT_LAST   = DTW'(DEAD_TIME - 1);
    localparam logic [DWW-1:0] DWELL_MAX = DWW'(MIN_DWELL);
    localparam logic [RDW-1:0] RAMP_LAST = RDW'(RAMP_DIV - 1);

    state_t             r_state;
    logic               r_s, r_lat, r_dt_act;
    logic [DTW-1:0]     r_dt_cnt;
    logic [DWW-1:0]     r_dwell;
    logic [RDW-1:0]     r_ramp_cnt;
    logic signed [31:0] r_theta;
    logic               r_gate_H, r_gate_L, r_fault;

    state_t             w_nx_state;
    logic               w_nx_s, w_nx_lat, w_nx_dt_act, w_commit, w_nx_drive;
    logic [DTW-1:0]     w_nx_dt_cnt;
    logic [DWW-1:0]     w_nx_dwell;
    logic [RDW-1:0]     w_nx_ramp_cnt;
    logic signed [31:0] w_nx_theta, w_theta_step;
    logic signed [33:0] w_diff;
    logic [33:0]        w_mag;
    logic [14:0]        w_iC_ext, w_iabs;
    logic               w_oc;

    // 15-bit magnitude so the most negative sample does not wrap
    assign w_iC_ext = {i_iC[13], i_iC};
    assign w_iabs   = i_iC[13] ? (~w_iC_ext + 15'd1) : w_iC_ext;
    assign w_oc     = (w_iabs > {1'b0, I_LIMIT});

    // One ramp step toward the target, clamped so it never passes it
    assign w_diff       = $signed({{2{i_theta_target[31]}}, i_theta_target})
                        - $signed({{2{r_theta[31]}}, r_theta});
    assign w_mag        = w_diff[33] ? 34'(-w_diff) : 34'(w_diff);
    assign w_theta_step = (w_mag <= {2'b00, THETA_STEP}) ? i_theta_target :
                          (w_diff[33] ? (r_theta - THETA_STEP) : (r_theta + THETA_STEP));

    always_comb begin
        w_nx_state    = r_state;
        w_nx_s        = r_s;
        w_nx_lat      = r_lat;
        w_nx_dt_act   = r_dt_act;
        w_nx_dt_cnt   = r_dt_cnt;
        w_nx_ramp_cnt = r_ramp_cnt;
        w_nx_theta    = r_theta;
        w_commit      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_nx_theta = i_theta_start;
                if (i_enable) begin
                    w_nx_state    = S_RAMP;
                    w_nx_ramp_cnt = '0;
                    w_nx_dt_act   = 1'b1;
                    w_nx_dt_cnt   = '0;
                    w_nx_lat      = i_sigma;
                end
            end
            S_RAMP, S_RUN: begin
                if (w_oc) begin
                    w_nx_state  = S_FAULT;
                    w_nx_dt_act = 1'b0;
                    w_nx_dt_cnt = '0;
                end else if (!i_enable) begin
                    w_nx_state  = S_IDLE;
                    w_nx_dt_act = 1'b0;
                    w_nx_dt_cnt = '0;
                    w_nx_theta  = i_theta_start;
                end else begin
                    if (r_dt_act) begin
                        if (r_dt_cnt == DT_LAST) begin
                            w_commit    = 1'b1;
                            w_nx_s      = r_lat;
                            w_nx_dt_act = 1'b0;
                            w_nx_dt_cnt = '0;
                        end else begin
                            w_nx_dt_cnt = r_dt_cnt + 1'b1;
                        end
                    end else if ((r_s != i_sigma) && (r_dwell == DWELL_MAX)) begin
                        w_nx_dt_act = 1'b1;
                        w_nx_dt_cnt = '0;
                        w_nx_lat    = i_sigma;
                    end
                    if (r_state == S_RUN) begin
                        w_nx_theta = i_theta_target;
                    end else if (r_theta == i_theta_target) begin
                        w_nx_state = S_RUN;
                    end else if (r_ramp_cnt == RAMP_LAST) begin
                        w_nx_ramp_cnt = '0;
                        w_nx_theta    = w_theta_step;
                    end else begin
                        w_nx_ramp_cnt = r_ramp_cnt + 1'b1;
                    end
                end
            end
            S_FAULT: begin
                if (i_fault_clr && !i_enable) begin
                    w_nx_state = S_IDLE;
                    w_nx_theta = i_theta_start;
                end
            end
            default: w_nx_state = S_IDLE;
        endcase
        w_nx_dwell = w_commit ? '0 : ((r_dwell == DWELL_MAX) ? r_dwell : r_dwell + 1'b1);
        w_nx_drive = ((w_nx_state == S_RAMP) || (w_nx_state == S_RUN)) && !w_nx_dt_act;
    end

    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            r_state    <= S_IDLE;
            r_s        <= 1'b0;
            r_lat      <= 1'b0;
            r_dt_act   <= 1'b0;
            r_dt_cnt   <= '0;
            r_dwell    <= DWELL_MAX;
            r_ramp_cnt <= '0;
            r_theta    <= '0;
            r_gate_H   <= 1'b0;
            r_gate_L   <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_nx_state;
            r_s        <= w_nx_s;
            r_lat      <= w_nx_lat;
            r_dt_act   <= w_nx_dt_act;
            r_dt_cnt   <= w_nx_dt_cnt;
            r_dwell    <= w_nx_dwell;
            r_ramp_cnt <= w_nx_ramp_cnt;
            r_theta    <= w_nx_theta;
            r_gate_H   <= w_nx_drive & w_nx_s;
            r_gate_L   <= w_nx_drive & ~w_nx_s;
            r_fault    <= (w_nx_state == S_FAULT);
        end
    end

    assign o_theta  = r_theta;
    assign o_gate_H = r_gate_H;
    assign o_gate_L = r_gate_L;
    assign o_state  = r_state;
    assign o_fault  = r_fault;

endmodule

// File: tb/tb_hybrid_sequencer.sv
// Scoreboarded bench for hybrid_sequencer: an event/timestamp reference model
// predicts the outputs after every edge; a monitor pops and compares them.
module tb_hybrid_sequencer;
    localparam int          DT    = 10;
    localparam int          MIND  = 50;
    localparam int          RDIV  = 100;
    localparam longint      STEP  = 1000;
    localparam int          ILIM  = 4000;

    logic               clk, rst_n, en, sig, fclr;
    logic signed [13:0] iC;
    logic signed [31:0] ts, tt;
    logic signed [31:0] o_theta;
    logic               o_gate_H, o_gate_L, o_fault;
    logic [1:0]         o_state;

    hybrid_sequencer #(
        .DEAD_TIME(DT), .MIN_DWELL(MIND), .RAMP_DIV(RDIV),
        .THETA_STEP(32'd1000), .I_LIMIT(14'd4000)
    ) dut (
        .i_clock(clk), .i_RESET(rst_n), .i_enable(en), .i_sigma(sig),
        .i_iC(iC), .i_theta_start(ts), .i_theta_target(tt), .i_fault_clr(fclr),
        .o_theta(o_theta), .o_gate_H(o_gate_H), .o_gate_L(o_gate_L),
        .o_state(o_state), .o_fault(o_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint theta;
        bit     gh, gl, flt;
        int     st;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;

    // Reference model: timestamps of edges instead of counters
    int     tcnt = 0;
    int     m_st = 0;
    bit     m_s = 0, m_pend = 0, m_lat = 0;
    int     m_tcommit = 0, m_tdone = 0, m_tramp = 0;
    longint m_rs = 0, m_theta = 0;

    task automatic model_edge();
        int     v, a;
        longint d, tgt;
        exp_t   e;
        bit     drive;
        tcnt++;
        v   = int'(iC);
        a   = (v < 0) ? -v : v;
        tgt = longint'(tt);
        if (!rst_n) begin
            m_st = 0; m_s = 0; m_pend = 0; m_theta = 0; m_tcommit = tcnt - MIND;
        end else begin
            case (m_st)
                0: begin
                    m_theta = longint'(ts);
                    if (en) begin
                        m_st = 1; m_tramp = tcnt; m_rs = longint'(ts);
                        m_pend = 1; m_lat = sig; m_tdone = tcnt + DT;
                    end
                end
                1, 2: begin
                    if (a > ILIM) begin
                        m_st = 3; m_pend = 0;
                    end else if (!en) begin
                        m_st = 0; m_pend = 0; m_theta = longint'(ts);
                    end else begin
                        if (m_pend && tcnt == m_tdone) begin
                            m_s = m_lat; m_pend = 0; m_tcommit = tcnt;
                        end else if (!m_pend && sig != m_s && (tcnt - 1 - m_tcommit) >= MIND) begin
                            m_pend = 1; m_lat = sig; m_tdone = tcnt + DT;
                        end
                        if (m_st == 2) m_theta = tgt;
                        else if (m_theta == tgt) m_st = 2;
                        else begin
                            d = longint'((tcnt - m_tramp) / RDIV) * STEP;
                            if (tgt >= m_rs) m_theta = (m_rs + d > tgt) ? tgt : m_rs + d;
                            else             m_theta = (m_rs - d < tgt) ? tgt : m_rs - d;
                        end
                    end
                end
                default: if (fclr && !en) begin m_st = 0; m_theta = longint'(ts); end
            endcase
        end
        drive   = (m_st == 1 || m_st == 2) && !m_pend;
        e.theta = m_theta;
        e.gh    = drive && m_s;
        e.gl    = drive && !m_s;
        e.st    = m_st;
        e.flt   = (m_st == 3);
        q.push_back(e);
    endtask

    task automatic cycle();
        model_edge();
        @(negedge clk);
    endtask

    // Monitor: one scoreboard entry per clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow at t=%0t: no expected entry", $time);
            end else begin
                e = q.pop_front();
                if (longint'(o_theta) != e.theta || o_gate_H != e.gh || o_gate_L != e.gl ||
                    int'(o_state) != e.st || o_fault != e.flt) begin
                    errors++;
                    $display("FAIL outputs t=%0t: got theta=%0d H=%0b L=%0b st=%0d flt=%0b want theta=%0d H=%0b L=%0b st=%0d flt=%0b",
                             $time, o_theta, o_gate_H, o_gate_L, o_state, o_fault,
                             e.theta, e.gh, e.gl, e.st, e.flt);
                end
            end
            checks++;
            if (o_gate_H && o_gate_L) begin
                errors++;
                $display("FAIL gate_overlap t=%0t: got H=1 L=1 want not both", $time);
            end
        end
    end

    initial begin
        int n, v;
        rst_n = 1'b0; en = 1'b0; sig = 1'b0; fclr = 1'b0; iC = '0; ts = 0; tt = 0;
        repeat (3) cycle();
        rst_n = 1'b1;
        repeat (2) cycle();

        // Upward soft start to RUN
        tt = 5000; sig = 1'b1; en = 1'b1;
        repeat (520) cycle();

        // Commutation 1->0 with dwell satisfied: gate_L edge latency
        repeat (60) cycle();
        sig = 1'b0;
        n = 0;
        while (n < 30) begin
            cycle();
            n++;
            if (o_gate_L) break;
        end
        checks++;
        if (n != DT + 1) begin
            errors++;
            $display("FAIL commutation_latency: got %0d cycles want %0d", n, DT + 1);
        end

        // Chatter starting 20 cycles after a commit
        repeat (20) cycle();
        for (int i = 0; i < 40; i++) begin
            sig = ~sig;
            cycle();
        end
        sig = 1'b1;
        repeat (80) cycle();

        // Overcurrent boundaries, then fault clear handshake
        iC = 14'sd4000;  repeat (5) cycle();
        iC = -14'sd4000; repeat (5) cycle();
        iC = -14'sd8192; cycle();
        iC = '0;         repeat (3) cycle();
        fclr = 1'b1;     repeat (5) cycle();
        en = 1'b0;       cycle();
        fclr = 1'b0;     repeat (3) cycle();

        // Async reset in the middle of the start-up dead time
        en = 1'b1; sig = 1'b1;
        repeat (5) cycle();
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_gate_H || o_gate_L || o_state != 2'd0 || o_fault || o_theta != 0) begin
            errors++;
            $display("FAIL async_reset: got H=%0b L=%0b st=%0d flt=%0b theta=%0d want all zero",
                     o_gate_H, o_gate_L, o_state, o_fault, o_theta);
        end
        cycle();
        rst_n = 1'b1; en = 1'b0;
        repeat (2) cycle();

        // Downward ramp, then a just-over-limit positive current
        ts = 5500; tt = 3000; en = 1'b1;
        repeat (320) cycle();
        iC = 14'sd4001; cycle();
        iC = '0; en = 1'b0; fclr = 1'b1; cycle();
        fclr = 1'b0; repeat (2) cycle();

        // Randomized operation
        for (int i = 0; i < 8000; i++) begin
            if (m_st == 0 && $urandom_range(0, 9) == 0) begin
                ts = int'($urandom_range(0, 16000)) - 8000;
                tt = int'($urandom_range(0, 16000)) - 8000;
            end
            if (m_st == 2 && $urandom_range(0, 199) == 0)
                tt = int'($urandom_range(0, 16000)) - 8000;
            if (en) begin
                if ($urandom_range(0, 599) == 0) en = 1'b0;
            end else if ($urandom_range(0, 9) == 0) en = 1'b1;
            if ($urandom_range(0, 24) == 0) sig = ~sig;
            if ($urandom_range(0, 1999) == 0) begin
                case ($urandom_range(0, 5))
                    0: v = 4001;  1: v = -4001; 2: v = 8191;
                    3: v = -8192; 4: v = 4000;  default: v = -4000;
                endcase
            end else begin
                v = int'($urandom_range(0, 6000)) - 3000;
            end
            iC   = 14'(v);
            fclr = ($urandom_range(0, 19) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
